// File: rtl/mult.sv
// -----------------------------------------------------------------------------
// mult: sequential signed multiplier (radix-2 Booth, one iteration per clock).
//
// Produces the full 2*WIDTH-bit two's-complement product of a and b, split
// into hi/lo for the HI/LO registers. The control unit holds mult_ctrl high
// for the whole operation and waits for the one-cycle done pulse.
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   mult_ctrl  in   1      run request (level); dropping it mid-run aborts
//   a          in   WIDTH  multiplicand (signed), sampled at the start edge
//   b          in   WIDTH  multiplier (signed), sampled at the start edge
//   hi         out  WIDTH  product[2*WIDTH-1:WIDTH]
//   lo         out  WIDTH  product[WIDTH-1:0]
//   done       out  1      one-cycle pulse when hi/lo have been updated
// -----------------------------------------------------------------------------
module mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_r;
    // acc is one bit wider than the operand so that subtracting
    // m = -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]     acc_r;
    logic [WIDTH-1:0]   q_r;
    logic               q_m1_r;
    logic [WIDTH:0]     m_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic [WIDTH:0]     acc_sum_s;
    logic [WIDTH:0]     acc_shift_s;
    logic [WIDTH-1:0]   q_shift_s;
    logic               q_m1_shift_s;
    logic               last_step_s;

    // Booth add/subtract selected by the current multiplier bit pair.
    always_comb begin
        acc_sum_s = acc_r;
        case ({q_r[0], q_m1_r})
            2'b01:   acc_sum_s = acc_r + m_r;
            2'b10:   acc_sum_s = acc_r - m_r;
            default: acc_sum_s = acc_r;
        endcase
    end

    // Arithmetic right shift of {acc, q, q_m1}, replicating the acc sign bit.
    always_comb begin
        acc_shift_s  = {acc_sum_s[WIDTH], acc_sum_s[WIDTH:1]};
        q_shift_s    = {acc_sum_s[0], q_r[WIDTH-1:1]};
        q_m1_shift_s = q_r[0];
    end

    // The iteration about to run is the final one.
    always_comb begin
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
    end

    // Control FSM, datapath registers and registered result/done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            acc_r   <= {(WIDTH+1){1'b0}};
            q_r     <= {WIDTH{1'b0}};
            q_m1_r  <= 1'b0;
            m_r     <= {(WIDTH+1){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            // done is only ever high for the single edge that completes a run.
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mult_ctrl) begin
                        acc_r   <= {(WIDTH+1){1'b0}};
                        q_r     <= b;
                        q_m1_r  <= 1'b0;
                        m_r     <= {a[WIDTH-1], a};
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (!mult_ctrl) begin
                        // Abort: partial result discarded, hi/lo untouched.
                        state_r <= IDLE;
                    end else begin
                        acc_r  <= acc_shift_s;
                        q_r    <= q_shift_s;
                        q_m1_r <= q_m1_shift_s;
                        cnt_r  <= cnt_r + CNT_W'(1);
                        if (last_step_s) begin
                            hi_r    <= acc_shift_s[WIDTH-1:0];
                            lo_r    <= q_shift_s;
                            done_r  <= 1'b1;
                            state_r <= HOLD;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                end
                HOLD: begin
                    // A held request must not retrigger; wait for it to drop.
                    if (!mult_ctrl) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign done = done_r;

endmodule

// File: tb/tb_mult.sv
// -----------------------------------------------------------------------------
// tb_mult: self-checking bench for mult. Directed vectors from a table, hand
// sequences for abort / reset mid-run, then random signed pairs. Expected
// products are pushed to a scoreboard queue at start and popped on done.
// -----------------------------------------------------------------------------
module tb_mult;

    logic        clk;
    logic        reset;
    logic        mult_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    mult #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mult_ctrl (mult_ctrl),
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full operation: start, scramble inputs after E0, expect done at E32,
    // check one-cycle width, optionally keep ctrl held, then drop ctrl.
    task automatic do_op(input logic [31:0] aa, input logic [31:0] bb,
                         input exp_t e, input int hold_cycles);
        int   edge_n;
        exp_t got_e;
        @(negedge clk);
        a = aa;
        b = bb;
        mult_ctrl = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);            // E0
        @(negedge clk);
        a = $urandom;
        b = $urandom;
        edge_n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done && edge_n == 0) edge_n = k;
            if (edge_n != 0) break;
        end
        chk("done_edge", 64'(edge_n), 64'd32);
        got_e = sb_q.pop_front();
        if (edge_n != 0) begin
            chk("hi", {32'd0, hi}, {32'd0, got_e.hi});
            chk("lo", {32'd0, lo}, {32'd0, got_e.lo});
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_width", {63'd0, done}, 64'd0);
        for (int k = 0; k < hold_cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_retrigger", {63'd0, done}, 64'd0);
        end
        mult_ctrl = 1'b0;
        @(posedge clk);            // HOLD -> IDLE
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ra;
        logic [31:0] rb;
        longint      p;

        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        mult_ctrl = 1'b0;
        a         = 32'd0;
        b         = 32'd0;

        vecs[0] = '{a: 32'd7,          b: 32'hFFFFFFFD, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB};
        vecs[1] = '{a: 32'h80000000, b: 32'h80000000, hi: 32'h40000000, lo: 32'h00000000};
        vecs[2] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h00000001};
        vecs[3] = '{a: 32'h7FFFFFFF, b: 32'h7FFFFFFF, hi: 32'h3FFFFFFF, lo: 32'h00000001};
        vecs[4] = '{a: 32'h00000000, b: 32'h12345678, hi: 32'h00000000, lo: 32'h00000000};
        vecs[5] = '{a: 32'd3,          b: 32'd5,          hi: 32'h00000000, lo: 32'h0000000F};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        reset = 1'b0;

        // Directed table; the first run also holds ctrl to check no retrigger.
        for (int i = 0; i < 6; i++) begin
            e.hi = vecs[i].hi;
            e.lo = vecs[i].lo;
            do_op(vecs[i].a, vecs[i].b, e, (i == 0) ? 6 : 0);
        end

        // Abort: start 0x10000 * 0x10000, drop ctrl after E10.
        @(negedge clk);
        a = 32'h00010000;
        b = 32'h00010000;
        mult_ctrl = 1'b1;
        @(posedge clk);            // E0
        repeat (10) @(posedge clk); // E1..E10
        @(negedge clk);
        mult_ctrl = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_done", {63'd0, done}, 64'd0);
        end
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd15);

        // Restart with the same operands.
        e.hi = 32'h00000001;
        e.lo = 32'h00000000;
        do_op(32'h00010000, 32'h00010000, e, 0);

        // Reset asserted so that edge E20 samples it.
        @(negedge clk);
        a = 32'h00010000;
        b = 32'h00010000;
        mult_ctrl = 1'b1;
        @(posedge clk);            // E0
        repeat (19) @(posedge clk); // E1..E19
        @(negedge clk);
        reset = 1'b1;
        mult_ctrl = 1'b0;
        @(posedge clk);            // E20
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk("reset_run_no_done", {63'd0, done}, 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("reset_run_hi", {32'd0, hi}, 64'd0);
        chk("reset_run_lo", {32'd0, lo}, 64'd0);

        // Random signed pairs against the 64-bit reference product.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 50 == 0) ra = 32'h80000000;
            if (i % 70 == 0) rb = 32'h80000000;
            p = longint'($signed(ra)) * longint'($signed(rb));
            e.hi = p[63:32];
            e.lo = p[31:0];
            do_op(ra, rb, e, 0);
        end

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult.md
# mult

Sequential signed multiplier for the multicycle datapath, the counterpart of the divider on the same control interface. It computes the full 64-bit two's-complement product of two 32-bit operands with radix-2 Booth recoding, one iteration per clock. It delivers the product split into `hi` and `lo` for the HI/LO registers. The control unit starts it with a level on `mult_ctrl` and waits for the one-cycle `done` pulse.

## Interface
- `WIDTH`, default 32: operand width. The product is 2×WIDTH. Only 32 is verified.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: reset is synchronous and active-high; the clock is `clk`.
- `mult_ctrl`  in  1: run request, held high by the control unit for the whole operation.
- `a`  in  WIDTH: multiplicand (signed), sampled at the start edge only.
- `b`  in  WIDTH: multiplier (signed), sampled at the start edge only.
- `hi`  out  WIDTH: product[2W-1:W].
- `lo`  out  WIDTH: product[W-1:0].
- `done`  out  1: one-cycle pulse when `hi`/`lo` have been updated.

## Operation
- Internal state:
  - `acc`: accumulator, WIDTH+1 bits, so that negating M = −2^(W−1) is representable.
  - `q`: WIDTH bits.
  - `q_m1`: 1 bit.
  - `m`: WIDTH+1 bits, sign-extended multiplicand.
  - `cnt`: iteration counter, 0..WIDTH.
- States are IDLE, RUN and HOLD.
- IDLE:
  - If `mult_ctrl`=1: load `acc`=0, `q`=b, `q_m1`=0, `m`=sext(a), `cnt`=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, every edge while `mult_ctrl`=1:
  - Booth step on {q[0], q_m1}:
    - 01: `acc`+=`m`.
    - 10: `acc`−=`m`.
    - 00 or 11: no change.
  - Then arithmetic right shift of {acc, q, q_m1} by 1, with acc[W] replicated.
  - `cnt`+=1.
- Last RUN step (`cnt`=WIDTH−1 before the edge):
  - Write `hi`=acc[W-1:0] and `lo`=q, both taken after that step's shift.
  - Set `done`=1 and go to HOLD.
- HOLD:
  - `done` returns to 0.
  - Stay in HOLD while `mult_ctrl`=1; go to IDLE when `mult_ctrl`=0. A held request therefore never retriggers.
- Abort: `mult_ctrl`=0 during RUN returns the block to IDLE at that edge.
  - `hi`, `lo` and `done` are unchanged.
  - The partial result is discarded.
- `hi`/`lo` change only at completion or reset. They hold the last product indefinitely.
- Arithmetic: the result is exact for all 2^64 signed operand pairs, including −2^31 × −2^31. There is no overflow or exception output.
- `a`/`b` changing after the start edge has no effect.

## Timing
- Reset (priority over everything):
  - `hi`=0, `lo`=0, `done`=0.
  - State IDLE, `cnt`=0; internal registers cleared.
  - Reset mid-RUN discards the operation with no `done` pulse.
- Latency: call the edge that samples `mult_ctrl`=1 in IDLE E0.
  - Iterations occur at E1..E32.
  - `hi`, `lo` and `done`=1 are visible after E32.
  - `done` is low again after E33.
- Minimum restart: after `done`, `mult_ctrl` low for ≥1 edge (HOLD→IDLE), then high again for the next E0.
- `done` is registered, never combinational from inputs.

## Test plan
- Reset, then a=7, b=−3 (0xFFFFFFFD), ctrl held:
  - `done` after exactly E32, one cycle wide.
  - `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - With ctrl still held, no second `done`.
- a=b=0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
- Sign corners, one run each:
  - a=b=0xFFFFFFFF → `hi`=0, `lo`=1.
  - a=b=0x7FFFFFFF → `hi`=0x3FFFFFFF, `lo`=0x00000001.
  - a=0, b=0x12345678 → 0:0.
- Abort and reset mid-run:
  - Complete 3×5 (`lo`=15, `hi`=0).
  - Start 0x10000×0x10000 and drop ctrl after E10: no `done`, `hi`/`lo` stay 0/15.
  - Restart the same operands: `hi`=1, `lo`=0.
  - Repeat with reset asserted at E20: `done` never pulses, `hi`=`lo`=0.
- Back-to-back and random:
  - Change `a`/`b` after E0; the result uses the sampled values.
  - 1000 random signed pairs with ctrl dropped one cycle between operations.
  - Each result must equal the 64-bit signed reference product, with `done` exactly at E32 of each run.
